fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_seq_pkg.sv | 29 ++
 rtl/instr_decode.sv | 21 ++
 rtl/fetch_sequencer.sv | 121 ++++++++++++
 tb/tb_fetch_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: FSM encoding, instruction-register
// field positions and default geometry.
package fetch_seq_pkg;

    localparam int DEF_PROG_LEN = 4;
    localparam int DEF_ADDR_W   = 2;

    localparam int IR_W        = 8;
    localparam int IR_RD1_MSB  = 7;
    localparam int IR_RD1_LSB  = 6;
    localparam int IR_RD2_MSB  = 5;
    localparam int IR_RD2_LSB  = 4;
    localparam int IR_WR_MSB   = 3;
    localparam int IR_WR_LSB   = 2;
    localparam int IR_WE_BIT   = 1;
    localparam int IR_RSVD_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_e;

    function automatic logic is_busy_state(input fsm_state_e st);
        return (st == ST_FETCH) || (st == ST_EXEC);
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Splits the instruction register into register-file addresses and the write bit.
// Bit 0 is reserved and deliberately ignored.
module instr_decode
    import fetch_seq_pkg::*;
(
    input  logic [IR_W-1:0] ir,
    output logic [1:0]      rd_addr1,
    output logic [1:0]      rd_addr2,
    output logic [1:0]      wr_addr,
    output logic            we_bit
);

    logic unused_rsvd_s;

    assign rd_addr1      = ir[IR_RD1_MSB:IR_RD1_LSB];
    assign rd_addr2      = ir[IR_RD2_MSB:IR_RD2_LSB];
    assign wr_addr       = ir[IR_WR_MSB:IR_WR_LSB];
    assign we_bit        = ir[IR_WE_BIT];
    assign unused_rsvd_s = ir[IR_RSVD_BIT];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer: walks the program counter over a fixed-length
// program, latches each instruction and presents decoded register-file controls.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int PROG_LEN = DEF_PROG_LEN,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              loop,
    input  logic              stall,
    output logic [ADDR_W-1:0] im_addr,
    output logic              im_cs,
    input  logic [IR_W-1:0]   im_data,
    output logic [1:0]        rd_addr1,
    output logic [1:0]        rd_addr2,
    output logic [1:0]        wr_addr,
    output logic              rf_we,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);

    fsm_state_e        state_r;
    fsm_state_e        next_state_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_next_s;
    logic [IR_W-1:0]   ir_r;
    logic              ir_load_s;
    logic              im_cs_r;
    logic              busy_r;
    logic              done_r;
    logic              we_bit_s;

    // Next-state, program-counter and IR-load decisions
    always_comb begin
        next_state_s = state_r;
        pc_next_s    = pc_r;
        ir_load_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_FETCH;
                    pc_next_s    = {ADDR_W{1'b0}};
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (stall) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_EXEC;
                    ir_load_s    = 1'b1;
                end
            end
            ST_EXEC: begin
                // The counter only wraps through the loop path, never by overflow
                if (stall) begin
                    next_state_s = ST_EXEC;
                end else if (pc_r != LAST_ADDR) begin
                    next_state_s = ST_FETCH;
                    pc_next_s    = pc_r + ADDR_W'(1'b1);
                end else if (loop) begin
                    next_state_s = ST_FETCH;
                    pc_next_s    = {ADDR_W{1'b0}};
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, PC, IR and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            pc_r    <= {ADDR_W{1'b0}};
            ir_r    <= 8'h00;
            im_cs_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            pc_r    <= pc_next_s;
            if (ir_load_s) begin
                ir_r <= im_data;
            end else begin
                ir_r <= ir_r;
            end
            im_cs_r <= (next_state_s == ST_FETCH);
            busy_r  <= is_busy_state(next_state_s);
            done_r  <= (next_state_s == ST_DONE);
        end
    end

    instr_decode u_decode (
        .ir       (ir_r),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .wr_addr  (wr_addr),
        .we_bit   (we_bit_s)
    );

    // Write strobe must react to stall in the same cycle, so it is gated rather than registered
    assign rf_we   = we_bit_s & (state_r == ST_EXEC) & ~stall & ~rst;
    assign im_addr = pc_r;
    assign im_cs   = im_cs_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized passes,
// checked against a per-instruction timeline model of fetch/execute.
module tb_fetch_sequencer;

    localparam int PROG_LEN = 4;
    localparam int ADDR_W   = 2;

    logic              clk;
    logic              rst;
    logic              start;
    logic              loop;
    logic              stall;
    logic [ADDR_W-1:0] im_addr;
    logic              im_cs;
    logic [7:0]        im_data;
    logic [1:0]        rd_addr1;
    logic [1:0]        rd_addr2;
    logic [1:0]        wr_addr;
    logic              rf_we;
    logic              busy;
    logic              done;

    logic [7:0]        prog [PROG_LEN];
    logic [7:0]        junk;
    int                fst [16];
    int                est [16];
    logic [7:0]        exp_ir;
    logic [ADDR_W-1:0] exp_addr;
    int                checks;
    int                errors;

    fetch_sequencer #(.PROG_LEN(PROG_LEN), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .loop     (loop),
        .stall    (stall),
        .im_addr  (im_addr),
        .im_cs    (im_cs),
        .im_data  (im_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .wr_addr  (wr_addr),
        .rf_we    (rf_we),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns garbage while stalled so an illegal IR load becomes visible
    always_comb im_data = stall ? junk : prog[im_addr];

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Flags are {busy, im_cs, done, rf_we}
    task automatic cyc(input logic st, input logic lp, input logic sa, input logic rs,
                       input logic [3:0] e_fl, input logic [ADDR_W-1:0] e_ad,
                       input logic [7:0] e_ir, input string tag);
        stall = st;
        loop  = lp;
        start = sa;
        rst   = rs;
        junk  = 8'($urandom);
        @(negedge clk);
        chk({tag, ".flags"}, {4'h0, busy, im_cs, done, rf_we}, {4'h0, e_fl});
        chk({tag, ".addr"}, {6'h00, im_addr}, {6'h00, e_ad});
        chk({tag, ".dec"}, {2'b00, rd_addr1, rd_addr2, wr_addr}, {2'b00, e_ir[7:2]});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input string nm);
        for (int c = 0; c < n; c++)
            cyc(rb(), rb(), 1'b0, 1'b0, 4'b0000, exp_addr, exp_ir, $sformatf("%s.idle%0d", nm, c));
    endtask

    task automatic clear_stalls();
        for (int i = 0; i < 16; i++) begin
            fst[i] = 0;
            est[i] = 0;
        end
    endtask

    // Runs n instructions (looping through the program) and finishes; abort_at resets
    // the sequencer in the first FETCH cycle of that instruction instead.
    task automatic run_pass(input int n, input int abort_at, input string nm);
        int   a;
        logic last;
        logic lp;
        cyc(rb(), rb(), 1'b1, 1'b0, 4'b0000, exp_addr, exp_ir, {nm, ".start"});
        for (int i = 0; i < n; i++) begin
            a = i % PROG_LEN;
            for (int s = 0; s <= fst[i]; s++) begin
                if (i == abort_at) begin
                    cyc(rb(), rb(), rb(), 1'b1, 4'b1100, 2'(a), exp_ir, {nm, ".rstcyc"});
                    exp_ir   = 8'h00;
                    exp_addr = '0;
                    cyc(rb(), rb(), 1'b0, 1'b0, 4'b0000, exp_addr, exp_ir, {nm, ".after_rst"});
                    return;
                end
                cyc(s < fst[i], rb(), rb(), 1'b0, 4'b1100, 2'(a), exp_ir,
                    $sformatf("%s.i%0d.fetch%0d", nm, i, s));
            end
            exp_ir = prog[a];
            for (int s = 0; s <= est[i]; s++) begin
                last = (s == est[i]);
                lp   = (last && a == PROG_LEN - 1) ? (i != n - 1) : rb();
                cyc(!last, lp, rb(), 1'b0, {3'b100, last & prog[a][1]}, 2'(a), exp_ir,
                    $sformatf("%s.i%0d.exec%0d", nm, i, s));
            end
        end
        exp_addr = 2'(PROG_LEN - 1);
        cyc(rb(), rb(), rb(), 1'b0, 4'b0010, exp_addr, exp_ir, {nm, ".done"});
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        loop     = 1'b0;
        stall    = 1'b0;
        junk     = 8'h00;
        exp_ir   = 8'h00;
        exp_addr = '0;
        prog[0]  = 8'b00_10_01_00;
        prog[1]  = 8'b10_00_01_00;
        prog[2]  = 8'b01_10_00_00;
        prog[3]  = 8'b10_11_00_00;
        clear_stalls();

        repeat (3) @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, exp_addr, exp_ir, "reset");

        run_pass(PROG_LEN, -1, "basic");
        idle(2, "basic");

        prog[2] = 8'b01_10_11_10;
        run_pass(PROG_LEN, -1, "we2");
        idle(1, "we2");

        prog[1] = 8'b00_01_10_10;
        est[1]  = 3;
        run_pass(PROG_LEN, -1, "stall");
        clear_stalls();
        idle(1, "stall");

        run_pass(3 * PROG_LEN, -1, "loop");
        idle(1, "loop");

        run_pass(PROG_LEN, 2, "abort");
        run_pass(PROG_LEN, -1, "restart");
        idle(1, "restart");

        for (int r = 0; r < 20; r++) begin
            for (int p = 0; p < PROG_LEN; p++) prog[p] = 8'($urandom);
            for (int i = 0; i < 16; i++) begin
                fst[i] = ($urandom_range(3, 0) == 0) ? $urandom_range(2, 1) : 0;
                est[i] = ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : 0;
            end
            run_pass(PROG_LEN * $urandom_range(3, 1), -1, $sformatf("rnd%0d", r));
            idle($urandom_range(2, 0), $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
